ram_port_master: RTL and testbench

Request-side controller for the team's single-port 128x32 RAM (synchronous write, combinational read). It accepts burst read/write commands over valid/ready handshakes, drives the RAM's `we`/`address`/`d` pins, and samples `q`. Read data is returned on a backpressured response stream. It sits between bus-side logic and the RAM instance, and is the only agent driving the RAM port.

---
 rtl/ram_port_master_pkg.sv | 15 +
 rtl/ram_port_if.sv | 40 ++++
 rtl/rpm_addr_ctr.sv | 51 +++++
 rtl/ram_port_master.sv | 158 +++++++++++++++
 tb/tb_ram_port_master.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_master_pkg.sv
// Shared types and default widths for the ram_port_master slice.
package ram_port_master_pkg;

    localparam int RPM_DATA_W = 32;
    localparam int RPM_ADDR_W = 7;
    localparam int RPM_LEN_W  = 7;

    typedef enum logic [1:0] {
        RPM_IDLE  = 2'd0,
        RPM_WRITE = 2'd1,
        RPM_READ  = 2'd2,
        RPM_INIT  = 2'd3
    } rpm_state_t;

endpackage

// File: rtl/ram_port_if.sv
// Bus-side handshake bundle for ram_port_master: command, write-data and
// read-response streams. The master modport is the bus-side agent, and the
// slave modport is the RAM port controller.
interface ram_port_if
    import ram_port_master_pkg::*;
#(
    parameter int DATA_W = RPM_DATA_W,
    parameter int ADDR_W = RPM_ADDR_W,
    parameter int LEN_W  = RPM_LEN_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/rpm_addr_ctr.sv
// Loadable wrapping word-address counter paired with a remaining-beats
// down-counter. 'last' flags the beat whose remaining count is zero.
// The WRITE, READ and INIT paths of ram_port_master all share it.
module rpm_addr_ctr
    import ram_port_master_pkg::*;
#(
    parameter int              ADDR_W     = RPM_ADDR_W,
    parameter int              LEN_W      = RPM_LEN_W,
    parameter logic [LEN_W-1:0] RST_REMAIN = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;

    // Load takes priority over advance; address wraps modulo the depth.
    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        if (load) begin
            addr_d   = load_addr;
            remain_d = load_len;
        end else if (advance) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - LEN_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            remain_q <= RST_REMAIN;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    assign addr = addr_q;
    assign last = (remain_q == '0);

endmodule

// File: rtl/ram_port_master.sv
// Request-side controller for a single-port RAM with synchronous write and
// combinational read. It takes burst commands, streams write data into the
// RAM, and returns read data through a one-entry backpressured slot.
// Optional build macro: RAM_PORT_MASTER_INIT_EN zero-fills the whole RAM
// after reset. This needs LEN_W >= ADDR_W so the sweep count fits the
// remaining-beats counter.
//
// state | meaning
// IDLE  | accept a command (held off while a read word is still pending)
// WRITE | one RAM write per wr_valid beat at cur_addr
// READ  | capture ram_q into the output slot whenever it can take a word
// INIT  | (macro only) write zero to every address, 0 upward
module ram_port_master
    import ram_port_master_pkg::*;
#(
    parameter int DATA_W = RPM_DATA_W,
    parameter int ADDR_W = RPM_ADDR_W,
    parameter int LEN_W  = RPM_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_if.slave         bus,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

`ifdef RAM_PORT_MASTER_INIT_EN
    localparam rpm_state_t       RST_STATE  = RPM_INIT;
    localparam logic [LEN_W-1:0] RST_REMAIN = LEN_W'((1 << ADDR_W) - 1);
`else
    localparam rpm_state_t       RST_STATE  = RPM_IDLE;
    localparam logic [LEN_W-1:0] RST_REMAIN = '0;
`endif

    rpm_state_t        state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              ctr_load;
    logic              ctr_advance;
    logic              ctr_last;
    logic [ADDR_W-1:0] cur_addr;
    logic              capture;
    logic              cmd_ready;
    logic              wr_ready;

    rpm_addr_ctr #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .RST_REMAIN (RST_REMAIN)
    ) u_addr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .load_addr (bus.cmd_addr),
        .load_len  (bus.cmd_len),
        .advance   (ctr_advance),
        .addr      (cur_addr),
        .last      (ctr_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter control and RAM pin drive. Handshake-facing
    // outputs are gated with rst_n so they read 0 while reset is held.
    always_comb begin
        state_d     = state_q;
        ctr_load    = 1'b0;
        ctr_advance = 1'b0;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        ram_we      = 1'b0;
        ram_d       = '0;
        capture     = 1'b0;
        case (state_q)
            RPM_IDLE: begin
                cmd_ready = !rd_valid_q && rst_n;
                if (bus.cmd_valid && cmd_ready) begin
                    ctr_load = 1'b1;
                    state_d  = bus.cmd_write ? RPM_WRITE : RPM_READ;
                end
            end
            RPM_WRITE: begin
                wr_ready = rst_n;
                ram_we   = bus.wr_valid && rst_n;
                ram_d    = bus.wr_data;
                if (bus.wr_valid) begin
                    ctr_advance = 1'b1;
                    if (ctr_last) begin
                        state_d = RPM_IDLE;
                    end
                end
            end
            RPM_READ: begin
                capture = !rd_valid_q || bus.rd_ready;
                if (capture) begin
                    ctr_advance = 1'b1;
                    if (ctr_last) begin
                        state_d = RPM_IDLE;
                    end
                end
            end
`ifdef RAM_PORT_MASTER_INIT_EN
            RPM_INIT: begin
                ram_we      = rst_n;
                ctr_advance = 1'b1;
                if (ctr_last) begin
                    state_d = RPM_IDLE;
                end
            end
`endif
            default: begin
                state_d = RPM_IDLE;
            end
        endcase
    end

    // Read output slot: a new capture wins over a simultaneous drain.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (capture) begin
            rd_valid_d = 1'b1;
            rd_data_d  = ram_q;
        end else if (rd_valid_q && bus.rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    // Read slot registers; reset drops any pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign ram_addr      = cur_addr;
    assign busy          = rst_n && ((state_q != RPM_IDLE) || rd_valid_q);
    assign bus.cmd_ready = cmd_ready;
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master driving a behavioural 128x32 RAM.
module tb_ram_port_master;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

    ram_port_master #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_q    (ram_q),
        .busy     (busy)
    );

    logic [DW-1:0] mem [0:127];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
    end
    assign ram_q = mem[ram_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0 || bus.wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got cmd_ready=%b busy=%b ram_we=%b wr_ready=%b expected all 0",
                     bus.cmd_ready, busy, ram_we, bus.wr_ready);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0 || ram_addr !== 7'd0 || ram_d !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got rd_valid=%b rd_data=%h ram_addr=%0d ram_d=%h expected zeros",
                     bus.rd_valid, bus.rd_data, ram_addr, ram_d);
        end
        rst_n = 1'b1;
        #1;
`ifdef RAM_PORT_MASTER_INIT_EN
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (bus.cmd_ready !== 1'b0 || busy !== 1'b1 || ram_we !== 1'b1 ||
                ram_addr !== AW'(i) || ram_d !== 32'h0) begin
                failures++;
                $display("FAIL init_sweep[%0d]: got cmd_ready=%b busy=%b we=%b addr=%0d d=%h expected 0 1 1 %0d 0",
                         i, bus.cmd_ready, busy, ram_we, ram_addr, ram_d, i);
            end
            tick();
        end
`endif
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b expected 1 0", bus.cmd_ready, busy);
        end
    endtask

`ifdef RAM_PORT_MASTER_INIT_EN
    task automatic test_init_readback();
        send_cmd(1'b0, 7'd0, 7'd127);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            tick();
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h0) begin
                failures++;
                $display("FAIL init_read[%0d]: got valid=%b data=%h expected 1 0", i, bus.rd_valid, bus.rd_data);
            end
        end
        tick();
        bus.rd_ready = 1'b0;
    endtask
`endif

    task automatic test_write_read();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
        send_cmd(1'b1, 7'd5, 7'd3);
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'hA0 + i;
            #1;
            checks++;
            if (ram_we !== 1'b1 || bus.wr_ready !== 1'b1 || ram_addr !== AW'(5 + i) || ram_d !== 32'hA0 + i) begin
                failures++;
                $display("FAIL wr_beat[%0d]: got we=%b wr_ready=%b addr=%0d d=%h expected 1 1 %0d %h",
                         i, ram_we, bus.wr_ready, ram_addr, ram_d, 5 + i, 32'hA0 + i);
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL wr_done: got cmd_ready=%b busy=%b we=%b expected 1 0 0", bus.cmd_ready, busy, ram_we);
        end
        send_cmd(1'b0, 7'd5, 7'd3);
        bus.rd_ready = 1'b1;
        checks++;
        if (ram_addr !== 7'd5 || bus.rd_valid !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL rd_first: got addr=%0d rd_valid=%b we=%b expected 5 0 0", ram_addr, bus.rd_valid, ram_we);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hA0 + i) begin
                failures++;
                $display("FAIL rd_beat[%0d]: got valid=%b data=%h expected 1 %h", i, bus.rd_valid, bus.rd_data, 32'hA0 + i);
            end
        end
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd_done: got rd_valid=%b cmd_ready=%b expected 0 1", bus.rd_valid, bus.cmd_ready);
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [3];
        exp_a[0] = 7'd126;
        exp_a[1] = 7'd127;
        exp_a[2] = 7'd0;
        send_cmd(1'b1, 7'd126, 7'd2);
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'(i + 1);
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== exp_a[i]) begin
                failures++;
                $display("FAIL wrap_wr[%0d]: got we=%b addr=%0d expected 1 %0d", i, ram_we, ram_addr, exp_a[i]);
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        send_cmd(1'b0, 7'd126, 7'd2);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ram_addr !== exp_a[i]) begin
                failures++;
                $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", i, ram_addr, exp_a[i]);
            end
            tick();
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'(i + 1)) begin
                failures++;
                $display("FAIL wrap_rd[%0d]: got valid=%b data=%h expected 1 %h", i, bus.rd_valid, bus.rd_data, i + 1);
            end
        end
        tick();
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int            got = 0;
        logic          stalled;
        logic [AW-1:0] prev_addr;
        send_cmd(1'b0, 7'd5, 7'd3);
        for (int k = 0; k < 40 && got < 4; k++) begin
            bus.rd_ready = (k % 3 == 0);
            #1;
            if (bus.rd_valid && bus.rd_ready) begin
                checks++;
                if (bus.rd_data !== 32'hA0 + got) begin
                    failures++;
                    $display("FAIL bp_word[%0d]: got %h expected %h", got, bus.rd_data, 32'hA0 + got);
                end
                got++;
            end
            stalled   = bus.rd_valid && !bus.rd_ready;
            prev_addr = ram_addr;
            tick();
            if (stalled) begin
                checks++;
                if (ram_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL bp_addr_hold: got %0d expected %0d", ram_addr, prev_addr);
                end
            end
        end
        bus.rd_ready = 1'b0;
        #1;
        checks++;
        if (got !== 4) begin
            failures++;
            $display("FAIL bp_count: got %0d words expected 4", got);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: got rd_valid=%b cmd_ready=%b expected 0 1", bus.rd_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_write_stall();
        logic [6:0] pat;
        int         b = 0;
        pat = 7'b1100011;
        send_cmd(1'b1, 7'd20, 7'd3);
        for (int k = 0; k < 7; k++) begin
            bus.wr_valid = pat[6 - k];
            bus.wr_data  = pat[6 - k] ? 32'hB0 + b : 32'hDEAD_BEEF;
            #1;
            checks++;
            if (ram_we !== pat[6 - k] || ram_addr !== AW'(20 + b)) begin
                failures++;
                $display("FAIL stall_cycle[%0d]: got we=%b addr=%0d expected %b %0d",
                         k, ram_we, ram_addr, pat[6 - k], 20 + b);
            end
            tick();
            if (pat[6 - k]) b++;
        end
        bus.wr_valid = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_done: got cmd_ready=%b busy=%b expected 1 0", bus.cmd_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[20 + i] !== 32'hB0 + i) begin
                failures++;
                $display("FAIL stall_mem[%0d]: got %h expected %h", 20 + i, mem[20 + i], 32'hB0 + i);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        send_cmd(1'b0, 7'd5, 7'd3);
        bus.rd_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0 || bus.cmd_ready !== 1'b0 || ram_addr !== 7'd0) begin
            failures++;
            $display("FAIL rst_mid_abort: got rd_valid=%b rd_data=%h cmd_ready=%b addr=%0d expected 0 0 0 0",
                     bus.rd_valid, bus.rd_data, bus.cmd_ready, ram_addr);
        end
        bus.rd_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
`ifdef RAM_PORT_MASTER_INIT_EN
        repeat (128) tick();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_release: got cmd_ready=%b rd_valid=%b expected 1 0", bus.cmd_ready, bus.rd_valid);
        end
`else
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_release: got cmd_ready=%b rd_valid=%b busy=%b expected 1 0 0",
                     bus.cmd_ready, bus.rd_valid, busy);
        end
        send_cmd(1'b0, 7'd20, 7'd0);
        bus.rd_ready = 1'b1;
        tick();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hB0) begin
            failures++;
            $display("FAIL rst_mid_persist: got valid=%b data=%h expected 1 000000b0", bus.rd_valid, bus.rd_data);
        end
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_final: got rd_valid=%b cmd_ready=%b expected 0 1", bus.rd_valid, bus.cmd_ready);
        end
        bus.rd_ready = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
`ifdef RAM_PORT_MASTER_INIT_EN
        test_init_readback();
`endif
        test_write_read();
        test_wrap();
        test_backpressure();
        test_write_stall();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
